// File: rtl/riscv_ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package riscv_ifq_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// DEPTH x {pc, inst} register array: one synchronous write port, one async read port.
// No control logic; the caller owns pointers, occupancy and write qualification.
module ifq_storage
    import riscv_ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  ifq_entry_t       wdata,
    input  logic [AW-1:0]    raddr,
    output ifq_entry_t       rdata
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// {pc, inst} FIFO between IMEM and decode; 1-cycle latency, or 0 with IFQ_BYPASS_EN via empty-queue bypass.
// Full queue deasserts fetch_ready (no pass-through); push while not ready sets sticky overflow.
module inst_fetch_queue
    import riscv_ifq_pkg::*;
#(
    parameter int DEPTH   = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fetch_valid,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic [XLEN-1:0]  fetch_inst,
    output logic             fetch_ready,
    input  logic             dec_ready,
    output logic             dec_valid,
    output logic [XLEN-1:0]  dec_pc,
    output logic [XLEN-1:0]  dec_inst,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             overflow_q;
    logic             stored_valid;
    logic             push;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;
    ifq_entry_t       wr_entry;
    ifq_entry_t       head;

    assign fetch_ready  = (count_q != FULL_CNT);
    assign stored_valid = (count_q != '0);
    assign push         = fetch_valid & fetch_ready;

`ifdef IFQ_BYPASS_EN
    assign bypass = ~stored_valid & fetch_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry consumed the same cycle never touches storage.
    assign wr_en = push & ~(bypass & dec_ready);
    assign rd_en = stored_valid & dec_ready;

    assign wr_entry.pc   = fetch_pc;
    assign wr_entry.inst = fetch_inst;

    ifq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (wr_en & ~flush & ~rst),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_comb begin
        dec_valid = stored_valid;
        dec_pc    = head.pc;
        dec_inst  = head.inst;
        if (bypass) begin
            dec_valid = 1'b1;
            dec_pc    = fetch_pc;
            dec_inst  = fetch_inst;
        end
        if (!dec_valid) begin
            dec_pc   = '0;
            dec_inst = NOP_INST;
        end
    end

    // Pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (fetch_valid && !fetch_ready && !flush) begin
            overflow_q <= 1'b1;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4), bypass expectations follow IFQ_BYPASS_EN.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_ready;
    logic        dec_ready;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic [2:0]  count;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .fetch_ready (fetch_ready),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .dec_pc      (dec_pc),
        .dec_inst    (dec_inst),
        .count       (count),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] pc);
        fetch_valid = v;
        fetch_pc    = pc;
        fetch_inst  = 32'h1000_0000 | pc;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dec_ready = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_inst = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;

        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_inst", dec_inst, 32'h00000013);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Fill to full with decode stalled.
        for (int i = 0; i < 4; i++) begin
            set_fetch(1'b1, 32'(i * 4));
            tick();
        end
        set_fetch(1'b0, 32'h0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("full_head_pc", dec_pc, 32'h0);

        // Push against a full queue.
        set_fetch(1'b1, 32'h10);
        tick();
        set_fetch(1'b0, 32'h0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);

        // Drain in order; 0x10 must not appear.
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 32'(dec_valid), 32'd1);
            chk("drain_pc", dec_pc, 32'(i * 4));
            chk("drain_inst", dec_inst, 32'h1000_0000 | 32'(i * 4));
            tick();
        end
        dec_ready = 1'b0;
        #1;
        chk("drained_valid", 32'(dec_valid), 32'd0);
        chk("drained_count", 32'(count), 32'd0);
        chk("drained_nop", dec_inst, 32'h00000013);
        chk("drained_pc", dec_pc, 32'h0);

        // Flush with concurrent push at count=2.
        set_fetch(1'b1, 32'h30); tick();
        set_fetch(1'b1, 32'h34); tick();
        set_fetch(1'b0, 32'h0);
        chk("pre_flush_count", 32'(count), 32'd2);
        flush = 1'b1;
        set_fetch(1'b1, 32'h20);
        tick();
        flush = 1'b0;
        set_fetch(1'b0, 32'h0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_dec_valid", 32'(dec_valid), 32'd0);
        chk("flush_keeps_ovf", 32'(overflow), 32'd1);
        set_fetch(1'b1, 32'h50); tick();
        set_fetch(1'b0, 32'h0);
        chk("post_flush_count", 32'(count), 32'd1);
        chk("post_flush_pc", dec_pc, 32'h50);
        dec_ready = 1'b1; tick(); dec_ready = 1'b0; #1;
        chk("post_flush_empty", 32'(count), 32'd0);

        // Streaming push+pop at count=2; pointers wrap several times.
        set_fetch(1'b1, 32'h100); tick();
        set_fetch(1'b1, 32'h104); tick();
        dec_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_fetch(1'b1, 32'h108 + 32'(4 * k));
            chk("stream_pc", dec_pc, 32'h100 + 32'(4 * k));
            chk("stream_count", 32'(count), 32'd2);
            tick();
        end
        set_fetch(1'b0, 32'h0);
        for (int k = 10; k < 12; k++) begin
            chk("stream_tail_pc", dec_pc, 32'h100 + 32'(4 * k));
            tick();
        end
        chk("stream_end_valid", 32'(dec_valid), 32'd0);

        // Latency from an empty queue, decode ready.
        set_fetch(1'b1, 32'h40);
`ifdef IFQ_BYPASS_EN
        chk("bypass_valid", 32'(dec_valid), 32'd1);
        chk("bypass_pc", dec_pc, 32'h40);
        tick();
        set_fetch(1'b0, 32'h0);
        chk("bypass_count", 32'(count), 32'd0);
        chk("bypass_after_valid", 32'(dec_valid), 32'd0);
`else
        chk("nobypass_valid", 32'(dec_valid), 32'd0);
        chk("nobypass_nop", dec_inst, 32'h00000013);
        tick();
        set_fetch(1'b0, 32'h0);
        chk("nobypass_next_valid", 32'(dec_valid), 32'd1);
        chk("nobypass_next_pc", dec_pc, 32'h40);
        chk("nobypass_count", 32'(count), 32'd1);
        tick();
        chk("nobypass_consumed", 32'(count), 32'd0);
`endif
        dec_ready = 1'b0;

        // Only reset clears the sticky overflow.
        rst = 1'b1; tick(); rst = 1'b0; #1;
        chk("rst_clears_ovf", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
